// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the memory arbiter: FSM states and requester identity.
// The state values are fixed so waveforms and debug tooling can decode them.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arbiter_block_counter.sv
// Issue/receive word counters for one block transfer, with terminal flags.
// issue_cnt is one bit wider so it can hold WORDS_PER_BLOCK once every command is out.
module block_counter #(
    parameter int  WORDS_PER_BLOCK = 8,
    localparam int CNT_W           = $clog2(WORDS_PER_BLOCK)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_inc,
    input  logic             recv_inc,
    input  logic             clr,
    output logic [CNT_W:0]   issue_cnt,
    output logic [CNT_W-1:0] recv_cnt,
    output logic             issue_done,
    output logic             recv_last
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_cnt <= '0;
            recv_cnt  <= '0;
        end else if (clr) begin
            issue_cnt <= '0;
            recv_cnt  <= '0;
        end else begin
            if (issue_inc)
                issue_cnt <= issue_cnt + (CNT_W+1)'(1);
            if (recv_inc)
                recv_cnt <= recv_cnt + CNT_W'(1);
        end
    end

    assign issue_done = (issue_cnt == (CNT_W+1)'(WORDS_PER_BLOCK));
    assign recv_last  = (recv_cnt == CNT_W'(WORDS_PER_BLOCK - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the shared main memory between the I-side and D-side miss handlers:
// block fills stream back word by word, D-side stores issue one write and wait for the ack.
//
// state | meaning
// IDLE  | no owner; arbitrate between i_req and d_req (alternate on contention)
// FILL  | issue block reads back to back, forward each returning word to the owner
// WRITE | single store command issued, waiting for the write acknowledge
// DONE  | one-cycle completion pulse to the owner; requests ignored
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int  WORDS_PER_BLOCK = 8,
    parameter int  ADDR_W          = 16,
    parameter int  DATA_W          = 16,
    localparam int WORD_W          = $clog2(WORDS_PER_BLOCK)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    output logic [DATA_W-1:0] fill_data,
    output logic [WORD_W-1:0] fill_word,
    output logic              i_fill_we,
    output logic              d_fill_we,
    output logic              i_done,
    output logic              d_done,
    output logic              busy
);

    // Blocks are aligned on WORDS_PER_BLOCK 2-byte words.
    localparam logic [ADDR_W-1:0] BLOCK_MASK = ~ADDR_W'(WORDS_PER_BLOCK * 2 - 1);

    state_t            state, state_next;
    owner_t            owner, last_owner, grant_owner;
    logic              grant;
    logic [ADDR_W-1:0] base_q, grant_addr;
    logic [DATA_W-1:0] wdata_q;

    logic [WORD_W:0]   issue_cnt;
    logic [WORD_W-1:0] recv_cnt;
    logic              issue_done, recv_last;
    logic              issue_inc, recv_inc, cnt_clr;

    block_counter #(.WORDS_PER_BLOCK(WORDS_PER_BLOCK)) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .issue_inc  (issue_inc),
        .recv_inc   (recv_inc),
        .clr        (cnt_clr),
        .issue_cnt  (issue_cnt),
        .recv_cnt   (recv_cnt),
        .issue_done (issue_done),
        .recv_last  (recv_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next  = state;
        grant       = 1'b0;
        grant_owner = OWNER_I;
        case (state)
            ST_IDLE: begin
                if (d_req && (!i_req || last_owner == OWNER_I)) begin
                    grant       = 1'b1;
                    grant_owner = OWNER_D;
                    state_next  = d_wr ? ST_WRITE : ST_FILL;
                end else if (i_req) begin
                    grant       = 1'b1;
                    grant_owner = OWNER_I;
                    state_next  = ST_FILL;
                end
            end
            ST_FILL: begin
                if (mem_rvalid && recv_last)
                    state_next = ST_DONE;
            end
            ST_WRITE: begin
                if (mem_rvalid)
                    state_next = ST_DONE;
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        grant_addr = i_addr & BLOCK_MASK;
        if (grant_owner == OWNER_D)
            grant_addr = d_wr ? d_addr : (d_addr & BLOCK_MASK);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner      <= OWNER_I;
            last_owner <= OWNER_I;
            base_q     <= '0;
            wdata_q    <= '0;
        end else begin
            if (grant) begin
                owner   <= grant_owner;
                base_q  <= grant_addr;
                wdata_q <= d_wdata;
            end
            if (state == ST_DONE)
                last_owner <= owner;
        end
    end

    // WRITE reuses issue_cnt so the store command goes out for exactly one cycle.
    assign mem_en    = ((state == ST_FILL) && !issue_done) ||
                       ((state == ST_WRITE) && (issue_cnt == '0));
    assign mem_wr    = (state == ST_WRITE) && (issue_cnt == '0);
    assign mem_addr  = mem_en ? (base_q + ADDR_W'({issue_cnt, 1'b0})) : '0;
    assign mem_wdata = mem_wr ? wdata_q : '0;

    assign issue_inc = mem_en;
    assign recv_inc  = (state == ST_FILL) && mem_rvalid;
    assign cnt_clr   = (state == ST_DONE);

    assign fill_data = mem_rdata;
    assign fill_word = recv_cnt;
    assign i_fill_we = recv_inc && (owner == OWNER_I);
    assign d_fill_we = recv_inc && (owner == OWNER_D);

    assign i_done = (state == ST_DONE) && (owner == OWNER_I);
    assign d_done = (state == ST_DONE) && (owner == OWNER_D);
    assign busy   = (state != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a vector table of single transactions against a
// latency-configurable memory model, plus hand sequences for contention and reset.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req, d_req, d_wr;
    logic [15:0] i_addr, d_addr, d_wdata;
    logic        mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata = 16'h0;
    logic        mem_rvalid = 1'b0;
    logic [15:0] fill_data;
    logic [2:0]  fill_word;
    logic        i_fill_we, d_fill_we, i_done, d_done, busy;

    mem_arbiter #(.WORDS_PER_BLOCK(8), .ADDR_W(16), .DATA_W(16)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .fill_data(fill_data), .fill_word(fill_word),
        .i_fill_we(i_fill_we), .d_fill_we(d_fill_we),
        .i_done(i_done), .d_done(d_done), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_d;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        var_lat;
        logic [15:0] exp_base;
        int          exp_cmds;
        int          exp_fills;
    } vec_t;

    typedef struct { logic [15:0] addr; logic wr; logic [15:0] wdata; int cyc; } cmd_t;
    typedef struct { logic d; logic both; logic [2:0] word; logic [15:0] data; int cyc; } fill_t;
    typedef struct { logic [15:0] addr; logic wr; int due; } pend_t;

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    last_due = 0;
    logic  var_lat = 1'b0;
    int    idone_n = 0;
    int    ddone_n = 0;
    cmd_t  cmd_q[$];
    fill_t fill_q[$];
    int    rv_q[$];
    pend_t pend_q[$];
    vec_t  vecs[6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Memory model: read data equals the word address, store ack carries junk data.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        mem_rvalid = 1'b0;
        mem_rdata  = 16'h0;
        if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = pend_q[0].wr ? 16'hDEAD : pend_q[0].addr;
            void'(pend_q.pop_front());
        end
    end

    always @(negedge clk) begin
        int due;
        if (mem_en) begin
            cmd_q.push_back('{addr: mem_addr, wr: mem_wr, wdata: mem_wdata, cyc: cyc});
            if (var_lat)
                due = ((last_due > cyc) ? last_due : cyc) + int'($urandom_range(1, 6));
            else
                due = ((cyc + 4) > last_due) ? (cyc + 4) : (last_due + 1);
            last_due = due;
            pend_q.push_back('{addr: mem_addr, wr: mem_wr, due: due});
        end
        if (i_fill_we || d_fill_we)
            fill_q.push_back('{d: d_fill_we, both: i_fill_we && d_fill_we,
                               word: fill_word, data: fill_data, cyc: cyc});
        if (mem_rvalid) rv_q.push_back(cyc);
        if (i_done) idone_n++;
        if (d_done) ddone_n++;
    end

    task automatic clear_logs();
        cmd_q.delete();
        fill_q.delete();
        rv_q.delete();
        idone_n = 0;
        ddone_n = 0;
    endtask

    task automatic wait_done(input logic want_d, output int t_done, output logic seen);
        seen   = 1'b0;
        t_done = 0;
        for (int k = 0; k < 300 && !seen; k++) begin
            @(negedge clk);
            if (want_d ? d_done : i_done) begin
                seen   = 1'b1;
                t_done = cyc;
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int   t_req, t_done;
        logic seen;
        logic [15:0] ea;
        clear_logs();
        var_lat = v.var_lat;
        @(posedge clk); #1;
        if (v.is_d) begin
            d_req = 1'b1; d_wr = v.wr; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            i_req = 1'b1; i_addr = v.addr;
        end
        t_req = cyc;
        wait_done(v.is_d, t_done, seen);
        chk({tag, "_done_seen"}, int'(seen), 1);
        @(posedge clk); #1;
        i_req = 1'b0;
        d_req = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk({tag, "_busy_after"}, int'(busy), 0);
        chk({tag, "_cmd_count"}, cmd_q.size(), v.exp_cmds);
        if (cmd_q.size() > 0)
            chk({tag, "_first_cmd_latency"}, cmd_q[0].cyc - t_req, 1);
        for (int k = 0; k < cmd_q.size() && k < v.exp_cmds; k++) begin
            ea = v.exp_base + 16'(2 * k);
            chk($sformatf("%s_cmd%0d_addr", tag, k), int'(cmd_q[k].addr), int'(ea));
            chk($sformatf("%s_cmd%0d_wr", tag, k), int'(cmd_q[k].wr), int'(v.is_d && v.wr));
            if (v.is_d && v.wr)
                chk($sformatf("%s_cmd%0d_wdata", tag, k), int'(cmd_q[k].wdata), int'(v.wdata));
        end
        chk({tag, "_fill_count"}, fill_q.size(), v.exp_fills);
        for (int k = 0; k < fill_q.size() && k < v.exp_fills; k++) begin
            ea = v.exp_base + 16'(2 * k);
            chk($sformatf("%s_fill%0d_owner", tag, k), int'({fill_q[k].both, fill_q[k].d}), int'({1'b0, v.is_d}));
            chk($sformatf("%s_fill%0d_word", tag, k), int'(fill_q[k].word), k);
            chk($sformatf("%s_fill%0d_data", tag, k), int'(fill_q[k].data), int'(ea));
        end
        chk({tag, "_i_done_count"}, idone_n, v.is_d ? 0 : 1);
        chk({tag, "_d_done_count"}, ddone_n, v.is_d ? 1 : 0);
        if (v.exp_fills > 0 && fill_q.size() > 0)
            chk({tag, "_done_after_last_fill"}, t_done - fill_q[fill_q.size()-1].cyc, 1);
        if (v.exp_fills == 0 && rv_q.size() > 0)
            chk({tag, "_done_after_ack"}, t_done - rv_q[0], 1);
    endtask

    initial begin
        int   td, ti, td2, n;
        logic seen;

        i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
        i_addr = 16'h0; d_addr = 16'h0; d_wdata = 16'h0;

        //          is_d  wr    addr      wdata     var   base      cmds fills
        vecs[0] = '{1'b0, 1'b0, 16'h1236, 16'h0000, 1'b0, 16'h1230, 8,   8};
        vecs[1] = '{1'b1, 1'b0, 16'h0ABC, 16'h0000, 1'b0, 16'h0AB0, 8,   8};
        vecs[2] = '{1'b1, 1'b1, 16'h0042, 16'hBEEF, 1'b0, 16'h0042, 1,   0};
        vecs[3] = '{1'b0, 1'b0, 16'h4000, 16'h0000, 1'b1, 16'h4000, 8,   8};
        vecs[4] = '{1'b0, 1'b0, 16'hFFF4, 16'h0000, 1'b0, 16'hFFF0, 8,   8};
        vecs[5] = '{1'b1, 1'b0, 16'h7FFF, 16'h0000, 1'b1, 16'h7FF0, 8,   8};

        #2;
        chk("reset_cmd", int'({mem_en, mem_wr}), 0);
        chk("reset_addr", int'(mem_addr), 0);
        chk("reset_wdata", int'(mem_wdata), 0);
        chk("reset_fill", int'({i_fill_we, d_fill_we, fill_word}), 0);
        chk("reset_done_busy", int'({i_done, d_done, busy}), 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // Contention right after reset: D first, then I; a fresh D request waits out the I fill.
        clear_logs();
        var_lat = 1'b0;
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = 16'h2000;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h3000;
        wait_done(1'b1, td, seen);
        chk("arb_d_first_done", int'(seen), 1);
        @(posedge clk); #1;
        d_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        d_addr = 16'h5000;
        d_req  = 1'b1;
        wait_done(1'b0, ti, seen);
        chk("arb_i_second_done", int'(seen), 1);
        chk("arb_no_preempt_d_done", ddone_n, 1);
        @(posedge clk); #1;
        i_req = 1'b0;
        wait_done(1'b1, td2, seen);
        chk("arb_d_third_done", int'(seen), 1);
        @(posedge clk); #1;
        d_req = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("arb_cmd_total", cmd_q.size(), 24);
        chk("arb_fill_total", fill_q.size(), 24);
        if (cmd_q.size() == 24 && fill_q.size() == 24) begin
            chk("arb_first_addr", int'(cmd_q[0].addr), 16'h3000);
            chk("arb_second_addr", int'(cmd_q[8].addr), 16'h2000);
            chk("arb_third_addr", int'(cmd_q[16].addr), 16'h5000);
            chk("arb_d_grant_after_i_done", cmd_q[16].cyc - ti, 2);
            chk("arb_fill_owner_1", int'(fill_q[7].d), 1);
            chk("arb_fill_owner_2", int'(fill_q[8].d || fill_q[15].d), 0);
            chk("arb_fill_owner_3", int'(fill_q[16].d), 1);
        end
        chk("arb_i_done_count", idone_n, 1);

        for (int v = 0; v < 6; v++)
            run_vec(vecs[v], $sformatf("vec%0d", v));

        // Reset in the middle of a fill; the stragglers must not reach the cache.
        clear_logs();
        var_lat = 1'b0;
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = 16'h1000;
        n = 0;
        for (int k = 0; k < 200 && n < 3; k++) begin
            @(negedge clk);
            if (i_fill_we) n++;
        end
        chk("rst_mid_reached_3", n, 3);
        @(posedge clk); #1;
        rst   = 1'b1;
        i_req = 1'b0;
        #1;
        chk("rst_mid_outputs", int'({mem_en, mem_wr, i_fill_we, d_fill_we, i_done, d_done, busy}), 0);
        chk("rst_mid_addr_word", int'({mem_addr, fill_word}), 0);
        fill_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("rst_mid_no_stray_fill", fill_q.size(), 0);
        chk("rst_mid_idle", int'(busy), 0);
        run_vec(vecs[0], "after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
